// File: rtl/al_exception_commit_ctrl_pkg.sv
// Shared types for the active-list exception commit controller.
// Cause codes are zero when an entry completed without an exception.
package al_excpt_pkg;

  localparam int EXCPT_W = 8;

  typedef logic [EXCPT_W-1:0] excpt_cause_t;

  localparam excpt_cause_t EXCPT_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } al_excpt_state_t;

endpackage

// File: rtl/al_exception_commit_ctrl_lane_scan.sv
// Combinational commit-window scan: finds the oldest excepting lane and
// produces the in-order commit mask that stops just below it.
module al_commit_lane_scan #(
  parameter int COMMIT_WIDTH = 4,
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1),
  parameter int IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic [COMMIT_WIDTH-1:0] eligible_i,
  input  logic [COMMIT_WIDTH-1:0] excepting_i,
  output logic [COMMIT_WIDTH-1:0] commit_mask_o,
  output logic [CNT_W-1:0]        commit_count_o,
  output logic [COMMIT_WIDTH-1:0] exc_onehot_o,
  output logic [IDX_W-1:0]        exc_idx_o,
  output logic                    exc_valid_o
);

  logic found_s;

  // Walk lanes oldest-first; everything at or above the first exception is held back.
  always_comb begin
    found_s        = 1'b0;
    commit_mask_o  = '0;
    commit_count_o = '0;
    exc_onehot_o   = '0;
    exc_idx_o      = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!found_s && excepting_i[i]) begin
        found_s         = 1'b1;
        exc_onehot_o[i] = 1'b1;
        exc_idx_o       = IDX_W'(i);
      end else if (!found_s) begin
        commit_mask_o[i] = eligible_i[i];
      end else begin
        commit_mask_o[i] = 1'b0;
      end
      commit_count_o = commit_count_o + CNT_W'(commit_mask_o[i]);
    end
    exc_valid_o = found_s;
  end

endmodule

// File: rtl/al_exception_commit_ctrl.sv
// Active-list commit controller: reads exception causes for the head window,
// retires in order, and sequences flush then trap redirect on an exception.
module al_exception_commit_ctrl
  import al_excpt_pkg::*;
#(
  parameter int COMMIT_WIDTH = 4,
  parameter int AL_DEPTH     = 128,
  parameter int AL_INDEX     = 7,
  parameter int EXCPT_WIDTH  = EXCPT_W,
  parameter int PC_WIDTH     = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [AL_INDEX-1:0]               alHead_i,
  input  logic [AL_INDEX:0]                 alCount_i,
  input  logic [COMMIT_WIDTH-1:0]           ready_i,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0]  commitPc_i,
  output logic [COMMIT_WIDTH*AL_INDEX-1:0]  rdAddr_o,
  input  logic [COMMIT_WIDTH*EXCPT_WIDTH-1:0] rdData_i,
  output logic [COMMIT_WIDTH-1:0]           commitMask_o,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0] commitCount_o,
  output logic                              exceptionFlush_o,
  output logic [EXCPT_WIDTH-1:0]            exceptionCause_o,
  output logic [PC_WIDTH-1:0]               exceptionPc_o,
  output logic [AL_INDEX-1:0]               exceptionIdx_o,
  input  logic                              flushAck_i,
  input  logic [PC_WIDTH-1:0]               trapVector_i,
  output logic                              redirectValid_o,
  output logic [PC_WIDTH-1:0]               redirectPc_o,
  input  logic                              redirectAck_i
);

  localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);
  localparam int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

  al_excpt_state_t         state_q, state_d;
  logic [EXCPT_WIDTH-1:0]  cause_q, cause_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [AL_INDEX-1:0]     idx_q, idx_d;
  logic [PC_WIDTH-1:0]     redirect_pc_q, redirect_pc_d;

  logic [COMMIT_WIDTH-1:0] eligible_s, excepting_s, exc_onehot_s;
  logic [IDX_W-1:0]        exc_idx_s;
  logic                    exc_valid_s, prefix_s;
  logic [EXCPT_WIDTH-1:0]  cause_sel_s;
  logic [PC_WIDTH-1:0]     pc_sel_s;

  function automatic logic [AL_INDEX-1:0] wrap_add(input logic [AL_INDEX-1:0] head,
                                                   input logic [AL_INDEX:0]   offset);
    logic [AL_INDEX:0] sum;
    sum = {1'b0, head} + offset;
    return AL_INDEX'(sum % (AL_INDEX+1)'(AL_DEPTH));
  endfunction

  // Read address per lane, independent of FSM state.
  always_comb begin
    rdAddr_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      rdAddr_o[i*AL_INDEX +: AL_INDEX] = wrap_add(alHead_i, (AL_INDEX+1)'(i));
    end
  end

  // Eligibility is a ready prefix within alCount; nothing is eligible during recovery.
  always_comb begin
    prefix_s    = (state_q == IDLE);
    eligible_s  = '0;
    excepting_s = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      prefix_s       = prefix_s & ready_i[i] & (alCount_i > (AL_INDEX+1)'(i));
      eligible_s[i]  = prefix_s;
      excepting_s[i] = prefix_s &
        (rdData_i[i*EXCPT_WIDTH +: EXCPT_WIDTH] != EXCPT_WIDTH'(EXCPT_NONE));
    end
  end

  al_commit_lane_scan #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .CNT_W       (CNT_W),
    .IDX_W       (IDX_W)
  ) u_scan (
    .eligible_i    (eligible_s),
    .excepting_i   (excepting_s),
    .commit_mask_o (commitMask_o),
    .commit_count_o(commitCount_o),
    .exc_onehot_o  (exc_onehot_s),
    .exc_idx_o     (exc_idx_s),
    .exc_valid_o   (exc_valid_s)
  );

  // One-hot select of the excepting lane's cause and PC.
  always_comb begin
    cause_sel_s = '0;
    pc_sel_s    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      cause_sel_s = cause_sel_s |
        (rdData_i[i*EXCPT_WIDTH +: EXCPT_WIDTH] & {EXCPT_WIDTH{exc_onehot_s[i]}});
      pc_sel_s = pc_sel_s | (commitPc_i[i*PC_WIDTH +: PC_WIDTH] & {PC_WIDTH{exc_onehot_s[i]}});
    end
  end

  // State and recovery registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cause_q       <= '0;
      pc_q          <= '0;
      idx_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next state and latch updates; each ack is only honoured in its own state.
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    idx_d         = idx_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (exc_valid_s) begin
          state_d = FLUSH;
          cause_d = cause_sel_s;
          pc_d    = pc_sel_s;
          idx_d   = wrap_add(alHead_i, (AL_INDEX+1)'(exc_idx_s));
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (flushAck_i) begin
          state_d       = REDIRECT;
          redirect_pc_d = trapVector_i;
        end else begin
          state_d = FLUSH;
        end
      end
      REDIRECT: begin
        if (redirectAck_i) begin
          state_d = IDLE;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    exceptionFlush_o = 1'b0;
    redirectValid_o  = 1'b0;
    case (state_q)
      FLUSH:    exceptionFlush_o = 1'b1;
      REDIRECT: redirectValid_o  = 1'b1;
      default: begin
        exceptionFlush_o = 1'b0;
        redirectValid_o  = 1'b0;
      end
    endcase
  end

  assign exceptionCause_o = cause_q;
  assign exceptionPc_o    = pc_q;
  assign exceptionIdx_o   = idx_q;
  assign redirectPc_o     = redirect_pc_q;

endmodule
